// File: rtl/traffic_phase_ctrl.sv
// Traffic light phase controller: RED -> GREEN -> YELLOW -> (WALK) -> RED.
// A 16-bit prescaler produces a one-clock tick; every phase lasts a fixed
// number of ticks. A synchronized pedestrian button requests a WALK phase
// that is served after the next YELLOW.
// The packed io_in/io_out byte carries clock, reset, inputs, lamps and the
// state code. io_out[7:6] always shows the registered FSM state.
module traffic_phase_ctrl #(
   parameter logic [15:0] PRESCALE     = 16'hFFFF,
   parameter int          RED_TICKS    = 6,
   parameter int          GREEN_TICKS  = 8,
   parameter int          YELLOW_TICKS = 2,
   parameter int          WALK_TICKS   = 4
) (
   input  logic [7:0] io_in,
   output logic [7:0] io_out
);

   typedef enum logic [1:0] {
      ST_RED    = 2'b00,
      ST_GREEN  = 2'b01,
      ST_YELLOW = 2'b10,
      ST_WALK   = 2'b11
   } state_t;

   // Dwell reload values: a phase of N ticks counts N-1 down to 0.
   localparam logic [3:0] RED_DW    = 4'(RED_TICKS - 1);
   localparam logic [3:0] GREEN_DW  = 4'(GREEN_TICKS - 1);
   localparam logic [3:0] YELLOW_DW = 4'(YELLOW_TICKS - 1);
   localparam logic [3:0] WALK_DW   = 4'(WALK_TICKS - 1);

   logic clk;
   logic rst_n;
   logic ped_req;
   logic fast;
   logic unused_in;

   assign clk       = io_in[0];
   assign rst_n     = io_in[1];
   assign ped_req   = io_in[2];
   assign fast      = io_in[3];
   assign unused_in = ^io_in[7:4];

   // ---------------------------------------------------------------
   // Prescaler
   // ---------------------------------------------------------------
   logic [15:0] tc;
   logic [15:0] pre_cnt_q, pre_cnt_d;
   logic        tick;

   // Terminal-count compare uses >= so a switch to a smaller TC while the
   // counter is already past it ticks right away instead of wrapping.
   always_comb begin
      tc        = fast ? 16'd15 : PRESCALE;
      tick      = (pre_cnt_q >= tc);
      pre_cnt_d = tick ? 16'd0 : (pre_cnt_q + 16'd1);
   end

   // Prescaler counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_cnt_q <= 16'd0;
      end else begin
         pre_cnt_q <= pre_cnt_d;
      end
   end

   // ---------------------------------------------------------------
   // Pedestrian button synchronizer and rising-edge detect
   // ---------------------------------------------------------------
   logic sync1_q, sync1_d;
   logic sync2_q, sync2_d;
   logic sync_prev_q, sync_prev_d;
   logic ped_rise;

   // Two-flop synchronizer plus one delay stage for edge detection.
   always_comb begin
      sync1_d     = ped_req;
      sync2_d     = sync1_q;
      sync_prev_d = sync2_q;
      ped_rise    = sync2_q & ~sync_prev_q;
   end

   // Synchronizer registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         sync_prev_q <= 1'b0;
      end else begin
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         sync_prev_q <= sync_prev_d;
      end
   end

   // ---------------------------------------------------------------
   // Phase FSM
   // ---------------------------------------------------------------
   state_t     state_q, state_d;
   logic [3:0] dwell_q, dwell_d;
   logic       pend_q, pend_d;
   logic [3:0] lamp_q, lamp_d;   // {walk, yellow, green, red}

   // Next-state, dwell, pending-request and lamp decode. The pending
   // clear on WALK entry is written after the set so it wins.
   always_comb begin
      state_d = state_q;
      dwell_d = dwell_q;
      pend_d  = pend_q;

      if (ped_rise && (state_q != ST_WALK)) begin
         pend_d = 1'b1;
      end

      if (tick) begin
         if (dwell_q != 4'd0) begin
            dwell_d = dwell_q - 4'd1;
         end else begin
            case (state_q)
               ST_RED: begin
                  state_d = ST_GREEN;
                  dwell_d = GREEN_DW;
               end
               ST_GREEN: begin
                  state_d = ST_YELLOW;
                  dwell_d = YELLOW_DW;
               end
               ST_YELLOW: begin
                  if (pend_q) begin
                     state_d = ST_WALK;
                     dwell_d = WALK_DW;
                     pend_d  = 1'b0;
                  end else begin
                     state_d = ST_RED;
                     dwell_d = RED_DW;
                  end
               end
               ST_WALK: begin
                  state_d = ST_RED;
                  dwell_d = RED_DW;
               end
               default: begin
                  state_d = ST_RED;
                  dwell_d = RED_DW;
               end
            endcase
         end
      end

      case (state_d)
         ST_RED:    lamp_d = 4'b0001;
         ST_GREEN:  lamp_d = 4'b0010;
         ST_YELLOW: lamp_d = 4'b0100;
         ST_WALK:   lamp_d = 4'b1001;
         default:   lamp_d = 4'b0001;
      endcase
   end

   // FSM registers; lamps are registered alongside the state they decode.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_RED;
         dwell_q <= RED_DW;
         pend_q  <= 1'b0;
         lamp_q  <= 4'b0001;
      end else begin
         state_q <= state_d;
         dwell_q <= dwell_d;
         pend_q  <= pend_d;
         lamp_q  <= lamp_d;
      end
   end

   assign io_out = {state_q, tick, pend_q, lamp_q};

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Bench for traffic_phase_ctrl with default parameters. Expected lamp/state
// bytes (tick bit masked) and phase lengths in clocks are queued before a
// run and checked as each phase change appears on io_out.
module tb_traffic_phase_ctrl;

   logic       clk = 1'b0;
   logic       clk_run = 1'b0;
   logic       rst_n;
   logic       ped_req;
   logic       fast;
   logic [3:0] junk = 4'd0;
   logic [7:0] io_in;
   logic [7:0] io_out;

   int total = 0;
   int bad   = 0;

   logic [7:0] exp_q[$];     // expected io_out & 8'hDF after each change
   int         len_q[$];     // expected clocks spent in the previous phase, -1 = unchecked

   assign io_in = {junk, fast, ped_req, rst_n, clk};

   traffic_phase_ctrl dut (
      .io_in  (io_in),
      .io_out (io_out)
   );

   // clock / reset block
   always #5 if (clk_run) clk = ~clk;

   // the unused upper input bits toggle freely
   always @(negedge clk) junk = 4'($urandom_range(0, 15));

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wait_state(input logic [1:0] code, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (io_out[7:6] === code) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // number of negedges until tick is seen high, 0 if the budget expires
   task automatic count_to_tick(input int budget, output int n);
      n = 0;
      for (int i = 1; i <= budget; i++) begin
         @(negedge clk);
         if (io_out[5] === 1'b1) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic push_exp(input logic [7:0] v, input int l);
      exp_q.push_back(v);
      len_q.push_back(l);
   endtask

   // scoreboard: pop one expectation per observed change of io_out
   task automatic sb_drain(input string tag, input int budget);
      logic [7:0] cur;
      logic [7:0] v;
      int len;
      int l;
      int waited;
      cur    = io_out & 8'hDF;
      len    = 0;
      waited = 0;
      while (exp_q.size() != 0) begin
         @(negedge clk);
         len++;
         waited++;
         if ((io_out & 8'hDF) !== cur) begin
            v = exp_q.pop_front();
            l = len_q.pop_front();
            total++;
            if ((io_out & 8'hDF) !== v) begin
               bad++;
               $display("FAIL %s phase: io_out=%h expected %h", tag, io_out & 8'hDF, v);
            end
            if (l >= 0) begin
               total++;
               if (len !== l) begin
                  bad++;
                  $display("FAIL %s length: %0d clocks expected %0d (entering %h)", tag, len, l, v);
               end
            end
            cur = io_out & 8'hDF;
            len = 0;
         end
         if (waited >= budget && exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL %s timeout: %0d expected changes never seen", tag, exp_q.size());
            exp_q.delete();
            len_q.delete();
         end
      end
   endtask

   task automatic test_reset();
      clk_run = 1'b0;
      clk     = 1'b0;
      fast    = 1'b1;
      ped_req = 1'b0;
      rst_n   = 1'b1;
      #3 rst_n = 1'b0;
      #1;
      total++;
      if (io_out !== 8'h01) begin
         bad++;
         $display("FAIL reset_no_clock: io_out=%h expected 01", io_out);
      end
      clk_run = 1'b1;
      repeat (4) @(negedge clk);
      total++;
      if (io_out !== 8'h01) begin
         bad++;
         $display("FAIL reset_held: io_out=%h expected 01", io_out);
      end
      rst_n = 1'b1;
      @(negedge clk);
      total++;
      if (io_out !== 8'h01) begin
         bad++;
         $display("FAIL reset_release: io_out=%h expected 01", io_out);
      end
   endtask

   task automatic test_tick_period();
      int n;
      fast = 1'b1;
      apply_reset();
      // counter runs 0..15 after release, tick lands in the 16th cycle
      count_to_tick(40, n);
      total++;
      if (n !== 15) begin
         bad++;
         $display("FAIL first_tick: after %0d clocks expected 15", n);
      end
      for (int k = 0; k < 2; k++) begin
         count_to_tick(40, n);
         total++;
         if (n !== 16) begin
            bad++;
            $display("FAIL tick_period: %0d clocks expected 16", n);
         end
      end
   endtask

   task automatic test_basic_cycle();
      fast    = 1'b1;
      ped_req = 1'b0;
      apply_reset();
      push_exp(8'h42, 96);
      push_exp(8'h84, 128);
      push_exp(8'h01, 32);
      push_exp(8'h42, 96);
      sb_drain("cycle", 600);
   endtask

   task automatic test_ped_walk();
      bit ok;
      fast = 1'b1;
      apply_reset();
      wait_state(2'b01, 200, ok);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL ped_wait_green: state=%b expected 01", io_out[7:6]);
      end
      ped_req = 1'b1;
      @(negedge clk);
      ped_req = 1'b0;
      @(negedge clk);
      total++;
      if (io_out[4] !== 1'b0) begin
         bad++;
         $display("FAIL ped_early: pending=%b expected 0", io_out[4]);
      end
      @(negedge clk);
      total++;
      if (io_out[4] !== 1'b1) begin
         bad++;
         $display("FAIL ped_pending: pending=%b expected 1", io_out[4]);
      end
      push_exp(8'h94, -1);
      push_exp(8'hC9, 32);
      push_exp(8'h01, 64);
      push_exp(8'h42, 96);
      sb_drain("walk", 400);
   endtask

   task automatic test_held_button();
      fast = 1'b1;
      apply_reset();
      ped_req = 1'b1;
      push_exp(8'h11, 3);
      push_exp(8'h52, 93);
      push_exp(8'h94, 128);
      push_exp(8'hC9, 32);
      push_exp(8'h01, 64);
      push_exp(8'h42, 96);
      push_exp(8'h84, 128);
      push_exp(8'h01, 32);
      push_exp(8'h42, 96);
      sb_drain("held", 1000);
      ped_req = 1'b0;
   endtask

   task automatic test_walk_press();
      bit ok;
      fast = 1'b1;
      apply_reset();
      repeat (2) @(negedge clk);
      ped_req = 1'b1;
      @(negedge clk);
      ped_req = 1'b0;
      wait_state(2'b11, 400, ok);
      total++;
      if (!ok || (io_out & 8'hDF) !== 8'hC9) begin
         bad++;
         $display("FAIL press_walk_entry: io_out=%h expected c9", io_out & 8'hDF);
      end
      @(negedge clk);
      ped_req = 1'b1;
      repeat (2) @(negedge clk);
      ped_req = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if ((io_out & 8'hDF) !== 8'hC9) begin
         bad++;
         $display("FAIL press_in_walk: io_out=%h expected c9", io_out & 8'hDF);
      end
      push_exp(8'h01, -1);
      push_exp(8'h42, 96);
      push_exp(8'h84, 128);
      push_exp(8'h01, 32);
      sb_drain("press", 400);
   endtask

   task automatic test_reset_mid_yellow();
      bit ok;
      int n;
      fast = 1'b1;
      apply_reset();
      ped_req = 1'b1;
      @(negedge clk);
      ped_req = 1'b0;
      wait_state(2'b10, 300, ok);
      repeat (4) @(negedge clk);
      total++;
      if (!ok || io_out[4] !== 1'b1) begin
         bad++;
         $display("FAIL mid_yellow_pending: state=%b pending=%b expected 10/1", io_out[7:6], io_out[4]);
      end
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (io_out !== 8'h01) begin
         bad++;
         $display("FAIL mid_yellow_reset: io_out=%h expected 01", io_out);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      count_to_tick(40, n);
      total++;
      if (n !== 15) begin
         bad++;
         $display("FAIL mid_yellow_first_tick: after %0d clocks expected 15", n);
      end
      total++;
      if (io_out[4] !== 1'b0) begin
         bad++;
         $display("FAIL mid_yellow_discard: pending=%b expected 0", io_out[4]);
      end
      push_exp(8'h42, -1);
      push_exp(8'h84, 128);
      push_exp(8'h01, 32);
      sb_drain("mid_yellow", 400);
   endtask

   task automatic test_fast_switch();
      int n;
      fast    = 1'b0;
      ped_req = 1'b0;
      apply_reset();
      repeat (200) @(negedge clk);
      total++;
      if (io_out[5] !== 1'b0) begin
         bad++;
         $display("FAIL slow_no_tick: tick=%b expected 0", io_out[5]);
      end
      fast = 1'b1;
      #1;
      total++;
      if (io_out[5] !== 1'b1) begin
         bad++;
         $display("FAIL switch_tick: tick=%b expected 1", io_out[5]);
      end
      for (int k = 0; k < 2; k++) begin
         count_to_tick(40, n);
         total++;
         if (n !== 16) begin
            bad++;
            $display("FAIL switch_period: %0d clocks expected 16", n);
         end
      end
      total++;
      if (io_out[7:6] !== 2'b00) begin
         bad++;
         $display("FAIL switch_state: state=%b expected 00", io_out[7:6]);
      end
   endtask

   initial begin
      test_reset();
      test_tick_period();
      test_basic_cycle();
      test_ped_walk();
      test_held_button();
      test_walk_press();
      test_reset_mid_yellow();
      test_fast_switch();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
